// File: rtl/sdp_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdp_fifo_pkg
// Description : Shared constants for the simple-dual-port-RAM FIFO
//               controller: default word width and RAM depth, and the depth
//               of the register output buffer behind the RAM read port.
// Revision    : 1.0 - initial release
// ============================================================================
package sdp_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_MEM_DEPTH  = 1024;
    localparam int OB_DEPTH           = 2;

endpackage : sdp_fifo_pkg
`default_nettype wire

// File: rtl/sdp_fifo_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : sdp_fifo_out_buf
// Description : Two-entry register FIFO that holds words returned by the RAM
//               read port until the downstream stream accepts them.
// Ports       : clk, rst (sync, active-low)
//               push / push_data : write one word
//               pop              : remove the head word
//               ob_cnt           : number of words held (0..2)
//               head_valid       : buffer non-empty
//               head_data        : oldest word
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_fifo_out_buf
    import sdp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            ob_cnt,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam logic [1:0] c_FULL = 2'(OB_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [OB_DEPTH];
    logic                  r_head;
    logic [1:0]            r_cnt;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_wr_idx;

    assign w_pop_ok  = pop && (r_cnt != 2'd0);
    // A push into a full buffer is still safe when the head leaves in the
    // same cycle: the write slot then coincides with the slot being freed.
    assign w_push_ok = push && ((r_cnt != c_FULL) || w_pop_ok);
    assign w_wr_idx  = r_head ^ r_cnt[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            r_head <= r_head ^ w_pop_ok;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: only slots covered by r_cnt are ever read out.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign ob_cnt     = r_cnt;
    assign head_valid = (r_cnt != 2'd0);
    assign head_data  = r_mem[r_head];

endmodule : sdp_fifo_out_buf
`default_nettype wire

// File: rtl/sdp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram_fifo_ctrl
// Description : Turns an external simple dual-port RAM into a valid/ready
//               FIFO. Accepted words are written sequentially through port A,
//               prefetched through port B (one-cycle read latency) and
//               presented through a two-entry output buffer.
// Ports       : clk, rst (sync, active-low)
//               s_valid/s_ready/s_data : upstream stream
//               m_valid/m_ready/m_data : downstream stream
//               level                  : words held (RAM + in flight + buffer)
//               addra/wena/dina        : RAM write port
//               addrb/renb/doutb/dvalb : RAM read port
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_fifo_ctrl
    import sdp_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic                  wena,
    output logic [DATA_WIDTH-1:0] dina,
    output logic [ADDR_WIDTH-1:0] addrb,
    output logic                  renb,
    input  logic [DATA_WIDTH-1:0] doutb,
    input  logic                  dvalb
);

    localparam logic [ADDR_WIDTH:0] c_MEM_FULL = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [2:0]          c_OB_SLOTS = 3'(OB_DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_inflight;

    logic [1:0]            w_ob_cnt;
    logic                  w_ob_valid;
    logic [DATA_WIDTH-1:0] w_ob_data;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_pop;
    logic                  w_cap;
    logic [2:0]            w_credit;

    assign s_ready = rst && (r_ram_cnt != c_MEM_FULL);
    assign w_wr    = s_valid && s_ready;
    assign m_valid = rst && w_ob_valid;
    assign w_pop   = m_valid && m_ready;

    // Buffer slots that will be taken once this cycle's pop and the pending
    // read have settled. Counting the pop lets a read issue every cycle while
    // the consumer keeps up, yet a new read never lacks a slot: its data lands
    // one cycle later, by which time the claimed slot is already free.
    assign w_credit = {1'b0, w_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd     = rst && (r_ram_cnt != '0) && (w_credit < c_OB_SLOTS);

    // Returned data is only ours when a read is outstanding; this drops
    // any read data that belonged to a request issued before a reset.
    assign w_cap = dvalb && r_inflight;

    assign wena  = w_wr;
    assign dina  = s_data;
    assign addra = rst ? r_wr_ptr : '0;
    assign renb  = w_rd;
    assign addrb = rst ? r_rd_ptr : '0;

    assign level = rst ? ({1'b0, r_ram_cnt}
                          + {{(ADDR_WIDTH+1){1'b0}}, r_inflight}
                          + {{ADDR_WIDTH{1'b0}}, w_ob_cnt})
                       : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            // Pointers wrap naturally because MEM_DEPTH is a power of two.
            if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            case ({w_wr, w_rd})
                2'b10:   r_ram_cnt <= r_ram_cnt + (ADDR_WIDTH+1)'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - (ADDR_WIDTH+1)'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
            r_inflight <= w_rd;
        end
    end

    sdp_fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (w_cap),
        .push_data  (doutb),
        .pop        (w_pop),
        .ob_cnt     (w_ob_cnt),
        .head_valid (w_ob_valid),
        .head_data  (w_ob_data)
    );

    assign m_data = w_ob_data;

endmodule : sdp_ram_fifo_ctrl
`default_nettype wire

// File: tb/tb_sdp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdp_ram_fifo_ctrl
// Description : Self-checking bench for sdp_ram_fifo_ctrl with a behavioural
//               one-cycle-latency RAM and a queue-based output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_ram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW+1:0] level;
    logic [AW-1:0] addra;
    logic          wena;
    logic [DW-1:0] dina;
    logic [AW-1:0] addrb;
    logic          renb;
    logic [DW-1:0] doutb;
    logic          dvalb;

    always #5 clk = ~clk;

    sdp_ram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level),
        .addra   (addra),
        .wena    (wena),
        .dina    (dina),
        .addrb   (addrb),
        .renb    (renb),
        .doutb   (doutb),
        .dvalb   (dvalb)
    );

    // Behavioural RAM: registered read, data valid one cycle after renb.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q  = '0;
    logic          ram_v  = 1'b0;
    logic          inject = 1'b0;

    always @(posedge clk) begin
        if (wena) mem[addra] <= dina;
        if (renb) ram_q <= mem[addrb];
        ram_v <= renb;
    end

    assign dvalb = ram_v | inject;
    assign doutb = inject ? 32'hDEAD_BEEF : ram_q;

    int            checks = 0;
    int            errors = 0;
    int            popped = 0;
    int            rd_wraps = 0;
    int            wr_wraps = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: records accepted words, compares every presented
    // output word (stalled or not) with the expected head.
    initial begin
        logic [AW-1:0] last_rd;
        logic [AW-1:0] last_wr;
        logic          have_rd;
        logic          have_wr;
        have_rd = 1'b0;
        have_wr = 1'b0;
        last_rd = '0;
        last_wr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (s_valid && s_ready) exp_q.push_back(s_data);
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("m_data", 64'(m_data), 64'(exp_q[0]));
                        if (m_ready) begin
                            void'(exp_q.pop_front());
                            popped++;
                        end
                    end
                end
                if (renb) begin
                    if (have_rd && last_rd == AW'(DEPTH-1) && addrb == '0) rd_wraps++;
                    last_rd = addrb;
                    have_rd = 1'b1;
                end
                if (wena) begin
                    if (have_wr && last_wr == AW'(DEPTH-1) && addra == '0) wr_wraps++;
                    last_wr = addra;
                    have_wr = 1'b1;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("push_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((level != '0 || exp_q.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        chk("drain_in_time", 64'(n < 5000), 64'd1);
    endtask

    initial begin
        int p0;
        int rw0;
        int ww0;
        int lvl_bad;

        // ---------------- reset state ----------------
        repeat (3) tick();
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_level",   64'(level),   64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        chk("post_rst_level",   64'(level),   64'd0);
        tick();

        // ---------------- single word ----------------
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'd350;
        @(negedge clk);
        chk("sw_wena",  64'(wena),  64'd1);
        chk("sw_addra", 64'(addra), 64'd0);
        chk("sw_dina",  64'(dina),  64'd350);
        chk("sw_renb0", 64'(renb),  64'd0);
        tick();                                 // E0: accepted
        s_valid = 1'b0;
        @(negedge clk);
        chk("sw_renb1", 64'(renb),    64'd1);
        chk("sw_addrb", 64'(addrb),   64'd0);
        chk("sw_mv_e0", 64'(m_valid), 64'd0);
        chk("sw_lvl_e0", 64'(level),  64'd1);
        tick();                                 // E1
        @(negedge clk);
        chk("sw_dvalb", 64'(dvalb),   64'd1);
        chk("sw_mv_e1", 64'(m_valid), 64'd0);
        tick();                                 // E2: captured
        @(negedge clk);
        chk("sw_mv_e2",   64'(m_valid), 64'd1);
        chk("sw_data_e2", 64'(m_data),  64'd350);
        tick();                                 // E3: popped
        @(negedge clk);
        chk("sw_mv_e3",  64'(m_valid), 64'd0);
        chk("sw_lvl_e3", 64'(level),   64'd0);
        tick();

        // ---------------- full ----------------
        m_ready = 1'b0;
        p0  = popped;
        rw0 = rd_wraps;
        for (int i = 0; i < DEPTH + 2; i++) push_word(DW'(i));
        repeat (3) tick();
        @(negedge clk);
        chk("full_level",   64'(level),   64'd1026);
        chk("full_s_ready", 64'(s_ready), 64'd0);
        tick();
        s_valid = 1'b1;
        s_data  = 32'd7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_refuse_wena", 64'(wena), 64'd0);
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("full_level_hold", 64'(level), 64'd1026);
        tick();
        m_ready = 1'b1;
        wait_drain();
        chk("full_drained",  64'(popped - p0), 64'd1026);
        chk("full_rd_wrap",  64'(rd_wraps > rw0), 64'd1);

        // ---------------- backpressure ----------------
        p0 = popped;
        fork
            begin
                for (int i = 0; i < 100; i++) push_word(DW'(i));
            end
            begin
                int n;
                n = 0;
                while (popped < p0 + 100 && n < 2000) begin
                    tick();
                    m_ready = ~m_ready;
                    n++;
                end
            end
        join
        m_ready = 1'b1;
        wait_drain();
        chk("bp_count", 64'(popped - p0), 64'd100);

        // ---------------- simultaneous ----------------
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(DW'(100 + i));
        repeat (3) tick();
        @(negedge clk);
        chk("sim_level_start", 64'(level), 64'd5);
        tick();
        rw0 = rd_wraps;
        ww0 = wr_wraps;
        lvl_bad = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(5000 + i);
            @(negedge clk);
            if (level != (AW+2)'(5) || !s_ready || !m_valid) lvl_bad++;
            tick();
        end
        s_valid = 1'b0;
        chk("sim_level_steady", 64'(lvl_bad), 64'd0);
        chk("sim_rd_wrap", 64'(rd_wraps > rw0), 64'd1);
        chk("sim_wr_wrap", 64'(wr_wraps > ww0), 64'd1);
        wait_drain();

        // ---------------- mid-operation reset ----------------
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_word(DW'(200 + i));
        repeat (3) tick();
        @(negedge clk);
        chk("mr_level10", 64'(level), 64'd10);
        tick();
        m_ready = 1'b1;                         // one pop frees a slot -> read issues
        @(negedge clk);
        chk("mr_renb", 64'(renb), 64'd1);
        tick();
        m_ready = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mr_inflight_dvalb", 64'(dvalb), 64'd1);
        chk("mr_s_ready", 64'(s_ready), 64'd0);
        chk("mr_m_valid", 64'(m_valid), 64'd0);
        chk("mr_wena",    64'(wena),    64'd0);
        chk("mr_renb_r",  64'(renb),    64'd0);
        chk("mr_level",   64'(level),   64'd0);
        chk("mr_addra",   64'(addra),   64'd0);
        chk("mr_addrb",   64'(addrb),   64'd0);
        tick();
        rst    = 1'b1;
        inject = 1'b1;                          // stray read data after reset
        @(negedge clk);
        chk("mr_stray_dvalb", 64'(dvalb), 64'd1);
        chk("mr_level_post",  64'(level), 64'd0);
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("mr_stray_ignored_mv",  64'(m_valid), 64'd0);
        chk("mr_stray_ignored_lvl", 64'(level),   64'd0);
        tick();
        p0 = popped;
        m_ready = 1'b1;
        push_word(32'd961);
        wait_drain();
        chk("mr_first_out_count", 64'(popped - p0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sdp_ram_fifo_ctrl
`default_nettype wire
